mem_stage: RTL and testbench

- Load/store stage of the RISC-V core, directly downstream of the execute stage.
- Consumes the execute stage's registered outputs: instruction type, memory type, destination, rs2 data and ALU result. For loads and stores, the ALU result is the effective address.
- Performs data-bus transactions with a req/ack handshake, lane-aligns store data and byte strobes, and extracts and extends load data.
- Presents a registered writeback bundle to the writeback stage and stalls upstream while a transaction is outstanding.

---
 rtl/core_pkg.sv | 22 ++
 rtl/mem_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types for pipeline-stage bundles.
// Instruction class and memory access size/signedness.
package core_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        ALU    = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        JUMP   = 3'd5
    } instr_type_t;

    typedef enum logic [2:0] {
        MT_B  = 3'd0,
        MT_H  = 3'd1,
        MT_W  = 3'd2,
        MT_BU = 3'd3,
        MT_HU = 3'd4
    } mem_type_t;

endpackage

// File: rtl/mem_stage.sv
// Load/store stage: req/ack data bus, lane alignment, load extension.
// Optional misaligned-access trap enabled by MEM_MISALIGN_TRAP_EN.
module mem_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  instr_type_t in_instr_type,
    input  mem_type_t   in_mem_type,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_res,
    output logic        stall,
    output instr_type_t out_instr_type,
    output logic [4:0]  out_dest,
    output logic        out_wb_en,
    output logic [31:0] out_wb_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic        misalign_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam int CW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    state_t      state, state_d;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;

    mem_type_t   lat_mt, lat_mt_d;
    logic [1:0]  lat_off, lat_off_d;
    logic [4:0]  lat_dest, lat_dest_d;
    logic        lat_load, lat_load_d;

    logic        mem_req_d, mem_we_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_wstrb_d;

    instr_type_t out_type_d;
    logic [4:0]  out_dest_d;
    logic        out_wb_en_d;
    logic [31:0] out_wb_data_d;
    logic        bus_err_d;
    logic        misal, misal_d;

    logic        is_mem, is_byte, is_half;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign stall   = (state == BUSY);
    assign cnt_inc = cnt + CW'(1);
    assign is_mem  = (in_instr_type == LOAD) ||
                     (in_instr_type == STORE);
    assign is_byte = (in_mem_type == MT_B) ||
                     (in_mem_type == MT_BU);
    assign is_half = (in_mem_type == MT_H) ||
                     (in_mem_type == MT_HU);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misal = (is_half && in_res[0]) ||
                   (in_mem_type == MT_W && in_res[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    // Store data replicated across lanes; strobe selects the target.
    always_comb begin
        st_wdata = in_rs2_data;
        st_wstrb = 4'b1111;
        unique case (1'b1)
            is_byte: begin
                st_wdata = {4{in_rs2_data[7:0]}};
                st_wstrb = 4'b0001 << in_res[1:0];
            end
            is_half: begin
                st_wdata = {2{in_rs2_data[15:0]}};
                st_wstrb = in_res[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        unique case (lat_off)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ;
        endcase
        ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = mem_rdata;
        unique case (lat_mt)
            MT_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            MT_BU:   ld_data = {24'd0, ld_byte};
            MT_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            MT_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        lat_mt_d      = lat_mt;
        lat_off_d     = lat_off;
        lat_dest_d    = lat_dest;
        lat_load_d    = lat_load;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_wstrb_d   = mem_wstrb;
        out_type_d    = NONE;
        out_dest_d    = out_dest;
        out_wb_en_d   = 1'b0;
        out_wb_data_d = out_wb_data;
        bus_err_d     = 1'b0;
        misal_d       = 1'b0;

        unique case (state)
            IDLE: begin
                if (is_mem && misal) begin
                    misal_d    = 1'b1;
                    out_dest_d = in_dest;
                end else if (is_mem) begin
                    state_d     = BUSY;
                    cnt_d       = '0;
                    lat_mt_d    = in_mem_type;
                    lat_off_d   = in_res[1:0];
                    lat_dest_d  = in_dest;
                    lat_load_d  = (in_instr_type == LOAD);
                    mem_req_d   = 1'b1;
                    mem_we_d    = (in_instr_type == STORE);
                    mem_addr_d  = {in_res[31:2], 2'b00};
                    mem_wdata_d = st_wdata;
                    mem_wstrb_d = (in_instr_type == STORE) ?
                                  st_wstrb : 4'b0000;
                end else begin
                    out_type_d    = in_instr_type;
                    out_dest_d    = in_dest;
                    out_wb_data_d = in_res;
                    out_wb_en_d   = (in_instr_type != NONE) &&
                                    (in_instr_type != BRANCH) &&
                                    (in_dest != 5'd0);
                end
            end
            BUSY: begin
                // Ack outranks a timeout landing on the same edge.
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    out_dest_d = lat_dest;
                    if (lat_load) begin
                        out_type_d    = LOAD;
                        out_wb_data_d = ld_data;
                        out_wb_en_d   = (lat_dest != 5'd0);
                    end else begin
                        out_type_d = STORE;
                    end
                end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_LIM) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            lat_mt         <= MT_B;
            lat_off        <= 2'b00;
            lat_dest       <= 5'd0;
            lat_load       <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 32'd0;
            mem_wdata      <= 32'd0;
            mem_wstrb      <= 4'd0;
            out_instr_type <= NONE;
            out_dest       <= 5'd0;
            out_wb_en      <= 1'b0;
            out_wb_data    <= 32'd0;
            bus_err        <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            lat_mt         <= lat_mt_d;
            lat_off        <= lat_off_d;
            lat_dest       <= lat_dest_d;
            lat_load       <= lat_load_d;
            mem_req        <= mem_req_d;
            mem_we         <= mem_we_d;
            mem_addr       <= mem_addr_d;
            mem_wdata      <= mem_wdata_d;
            mem_wstrb      <= mem_wstrb_d;
            out_instr_type <= out_type_d;
            out_dest       <= out_dest_d;
            out_wb_en      <= out_wb_en_d;
            out_wb_data    <= out_wb_data_d;
            bus_err        <= bus_err_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= misal_d;
    end
`else
    assign misalign_err = 1'b0;
    logic unused_misal;
    assign unused_misal = misal_d;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expectations.
// Built with TIMEOUT_CYCLES = 4.
module tb_mem_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    instr_type_t in_instr_type;
    mem_type_t   in_mem_type;
    logic [4:0]  in_dest;
    logic [31:0] in_rs2_data;
    logic [31:0] in_res;
    logic        stall;
    instr_type_t out_instr_type;
    logic [4:0]  out_dest;
    logic        out_wb_en;
    logic [31:0] out_wb_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;
    logic        misalign_err;

    int errs = 0;
    int checks = 0;
    int stall_n;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_instr_type(in_instr_type),
        .in_mem_type(in_mem_type),
        .in_dest(in_dest),
        .in_rs2_data(in_rs2_data),
        .in_res(in_res),
        .stall(stall),
        .out_instr_type(out_instr_type),
        .out_dest(out_dest),
        .out_wb_en(out_wb_en),
        .out_wb_data(out_wb_data),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .bus_err(bus_err),
        .misalign_err(misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input instr_type_t t, input mem_type_t m,
                         input logic [4:0] d, input logic [31:0] rs2,
                         input logic [31:0] res);
        in_instr_type = t;
        in_mem_type   = m;
        in_dest       = d;
        in_rs2_data   = rs2;
        in_res        = res;
    endtask

    task automatic do_load(input string tag, input mem_type_t m,
                           input logic [4:0] d, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp,
                           input logic exp_en);
        drive(LOAD, m, d, 32'd0, addr);
        tick;
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_strb"}, mem_wstrb, 0);
        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        mem_rdata = rd;
        mem_ack   = 1'b1;
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check({tag, "_data"}, out_wb_data, exp);
        check({tag, "_en"}, out_wb_en, exp_en);
        check({tag, "_type"}, out_instr_type, LOAD);
        check({tag, "_dest"}, out_dest, d);
        check({tag, "_stall"}, stall, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        #2;
        check("rst_stall", stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_type", out_instr_type, NONE);
        check("rst_wb_en", out_wb_en, 0);
        check("rst_wb_data", out_wb_data, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_misal", misalign_err, 0);
        tick;
        rst_n = 1'b1;

        drive(ALU, MT_W, 5'd5, 32'd0, 32'h1234);
        tick;
        check("alu_en", out_wb_en, 1);
        check("alu_data", out_wb_data, 32'h1234);
        check("alu_type", out_instr_type, ALU);
        check("alu_dest", out_dest, 5);
        check("alu_stall", stall, 0);
        drive(ALU, MT_W, 5'd0, 32'd0, 32'h1234);
        tick;
        check("alu_d0_en", out_wb_en, 0);
        check("alu_d0_stall", stall, 0);
        drive(BRANCH, MT_W, 5'd3, 32'd0, 32'h40);
        tick;
        check("br_en", out_wb_en, 0);
        check("br_type", out_instr_type, BRANCH);

        drive(STORE, MT_B, 5'd2, 32'hAABBCCDD, 32'h103);
        tick;
        stall_n = stall ? 1 : 0;
        check("sb_req", mem_req, 1);
        check("sb_we", mem_we, 1);
        check("sb_addr", mem_addr, 32'h100);
        check("sb_strb", mem_wstrb, 4'b1000);
        check("sb_wdata", mem_wdata, 32'hDDDDDDDD);
        check("sb_bubble", out_instr_type, NONE);
        drive(ALU, MT_W, 5'd7, 32'd0, 32'h55);
        repeat (2) begin
            tick;
            if (stall) stall_n++;
        end
        check("sb_hold_addr", mem_addr, 32'h100);
        check("sb_hold_strb", mem_wstrb, 4'b1000);
        check("sb_hold_req", mem_req, 1);
        check("sb_busy_type", out_instr_type, NONE);
        tick;
        if (stall) stall_n++;
        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check("sb_stall_cycles", stall_n, 4);
        check("sb_done_stall", stall, 0);
        check("sb_done_req", mem_req, 0);
        check("sb_done_type", out_instr_type, STORE);
        check("sb_done_en", out_wb_en, 0);
        check("sb_done_berr", bus_err, 0);

        drive(STORE, MT_H, 5'd4, 32'h1234ABCD, 32'h202);
        tick;
        check("sh_wdata", mem_wdata, 32'hABCDABCD);
        check("sh_strb", mem_wstrb, 4'b1100);
        check("sh_addr", mem_addr, 32'h200);
        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check("sh_type", out_instr_type, STORE);

        drive(STORE, MT_W, 5'd4, 32'hCAFEF00D, 32'h300);
        tick;
        check("sw_wdata", mem_wdata, 32'hCAFEF00D);
        check("sw_strb", mem_wstrb, 4'b1111);
        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check("sw_type", out_instr_type, STORE);
        tick;
        check("gap_req", mem_req, 0);
        check("gap_stall", stall, 0);

        do_load("lh", MT_H, 5'd9, 32'h202, 32'h80FF7F01, 32'hFFFF80FF, 1);
        do_load("lhu", MT_HU, 5'd9, 32'h202, 32'h80FF7F01, 32'h000080FF, 1);
        do_load("lb", MT_B, 5'd9, 32'h203, 32'h80FF7F01, 32'hFFFFFF80, 1);
        do_load("lbu0", MT_BU, 5'd8, 32'h200, 32'h80FF7F01, 32'h00000001, 1);
        do_load("lbu1", MT_BU, 5'd8, 32'h201, 32'h80FF7F01, 32'h0000007F, 1);
        do_load("lh_d0", MT_H, 5'd0, 32'h200, 32'h80FF7F01, 32'h00007F01, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        drive(LOAD, MT_W, 5'd10, 32'd0, 32'h102);
        tick;
        check("lw_mis_req", mem_req, 0);
        check("lw_mis_err", misalign_err, 1);
        check("lw_mis_stall", stall, 0);
        check("lw_mis_type", out_instr_type, NONE);
        check("lw_mis_en", out_wb_en, 0);
        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        tick;
        check("lw_mis_pulse", misalign_err, 0);
`else
        do_load("lw", MT_W, 5'd10, 32'h102, 32'h80FF7F01, 32'h80FF7F01, 1);
        check("lw_misal_tied", misalign_err, 0);
`endif

        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_stall", stall, 0);
        check("idle_ack_type", out_instr_type, NONE);

        drive(LOAD, MT_W, 5'd11, 32'd0, 32'h400);
        tick;
        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        repeat (3) tick;
        check("to_req_held", mem_req, 1);
        check("to_stall_held", stall, 1);
        check("to_berr_early", bus_err, 0);
        tick;
        check("to_req", mem_req, 0);
        check("to_berr", bus_err, 1);
        check("to_stall", stall, 0);
        check("to_type", out_instr_type, NONE);
        check("to_en", out_wb_en, 0);
        tick;
        check("to_berr_pulse", bus_err, 0);

        drive(LOAD, MT_W, 5'd12, 32'd0, 32'h500);
        tick;
        check("mrst_stall_pre", stall, 1);
        check("mrst_req_pre", mem_req, 1);
        drive(NONE, MT_W, 5'd0, 32'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_req", mem_req, 0);
        check("mrst_stall", stall, 0);
        #2;
        rst_n = 1'b1;
        drive(ALU, MT_W, 5'd6, 32'd0, 32'hBEEF);
        tick;
        check("mrst_alu_en", out_wb_en, 1);
        check("mrst_alu_data", out_wb_data, 32'hBEEF);
        check("mrst_alu_type", out_instr_type, ALU);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
